// File: rtl/row_assembler_if.sv
// Element stream from the DMA plus the row-write port toward the vector register file.
// The slave view is the assembler; the master view is the DMA/register-file side.
interface row_assembler_if #(
    parameter int wordSize = 32,
    parameter int words    = 16,
    parameter int NoOfElem = 16
);
    logic [wordSize-1:0]             in_data;
    logic                            in_valid;
    logic                            in_ready;
    logic [words-1:0][wordSize-1:0]  rowData;
    logic [$clog2(NoOfElem)-1:0]     rowAddr;
    logic                            rowWE;

    modport slave (
        input  in_data, in_valid,
        output in_ready, rowData, rowAddr, rowWE
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, rowData, rowAddr, rowWE
    );
endinterface

// File: rtl/row_assembler.sv
// Packs a serial element stream into register-file rows, one row write per `words`
// accepted elements, until NoOfElem rows are loaded; then pulses done.
module row_assembler #(
    parameter int wordSize = 32,
    parameter int words    = 16,
    parameter int NoOfElem = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic              done,
    row_assembler_if.slave    bus
);
    localparam int WW = $clog2(words);
    localparam int RW = $clog2(NoOfElem);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                          state;
    logic [WW-1:0]                   wcnt;
    logic [RW-1:0]                   rcnt;
    logic [words-1:0][wordSize-1:0]  buffer;
    logic                            accept;

    assign bus.in_ready = (state == FILL);
    assign accept       = bus.in_valid && (state == FILL);

    // rowData is a separate copy of the buffer so it holds steady while the next row fills;
    // the final element is merged straight from in_data on the accepting edge.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            buffer      <= '0;
            bus.rowData <= '0;
            bus.rowAddr <= '0;
            bus.rowWE   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            bus.rowWE <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FILL;
                        wcnt  <= '0;
                        rcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        buffer[wcnt] <= bus.in_data;
                        if (wcnt == WW'(words - 1)) begin
                            wcnt                   <= '0;
                            state                  <= WRITE;
                            bus.rowWE              <= 1'b1;
                            bus.rowAddr            <= rcnt;
                            bus.rowData            <= buffer;
                            bus.rowData[words-1]   <= bus.in_data;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (rcnt == RW'(NoOfElem - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        rcnt  <= rcnt + 1'b1;
                        state <= FILL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rcnt  <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_assembler.sv
// Directed bench for row_assembler: expected rows are queued as they are streamed and
// compared against each rowWE strobe; timing, handshake and reset behaviour are checked inline.
module tb_row_assembler;
    localparam int WS = 32;
    localparam int WD = 16;
    localparam int NE = 16;

    typedef logic [WD-1:0][WS-1:0] row_t;
    typedef struct {
        logic [3:0] addr;
        row_t       data;
    } exp_t;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    row_assembler_if #(.wordSize(WS), .words(WD), .NoOfElem(NE)) bus ();

    row_assembler #(.wordSize(WS), .words(WD), .NoOfElem(NE)) dut (
        .clk   (clk),
        .RESET (RESET),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t got;
    int   checks      = 0;
    int   errors      = 0;
    int   writes      = 0;
    int   done_count  = 0;
    int   busy_cycles = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every row strobe must match the oldest queued row; a strobe with nothing queued is a failure.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_count++;
        if (bus.rowWE === 1'b1) begin
            writes++;
            check("in_ready_during_write", bus.in_ready, 1'b0);
            check("write_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("rowAddr", bus.rowAddr, got.addr);
                check("rowData", bus.rowData, got.data);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [WS-1:0] d, input bit stall);
        int guard;
        guard = 0;
        if (stall) begin
            while ($urandom_range(1) == 1) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_timeout", bus.in_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_matrix(input int base, input bit stall, input int restart_row,
                               input int stop_row, input int stop_k);
        row_t       rd;
        logic [WS-1:0] v;
        exp_t       e;
        for (int r = 0; r < NE; r++) begin
            for (int k = 0; k < WD; k++) begin
                if (r == stop_row && k == stop_k) return;
                v     = WS'(base + 16 * r + k);
                rd[k] = v;
                if (k == WD - 1) begin
                    e.addr = 4'(r);
                    e.data = rd;
                    sb.push_back(e);
                end
                if (r == restart_row && k == 0) start = 1'b1;
                if (r == restart_row && k == 1) start = 1'b0;
                send(v, stall);
                if (k == WD - 1) check("write_latency", bus.rowWE, 1'b1);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset then idle with no start
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_rowData", bus.rowData, '0);
            check("idle_rowAddr", bus.rowAddr, '0);
            check("idle_rowWE", bus.rowWE, 1'b0);
            check("idle_in_ready", bus.in_ready, 1'b0);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
        end

        // Full matrix, no stalls: minimum timing
        busy_cycles = 0;
        done_count  = 0;
        writes      = 0;
        do_start();
        check("busy_after_start", busy, 1'b1);
        send_matrix(0, 1'b0, -1, NE, 0);
        wait_done();
        @(negedge clk);
        check("nostall_busy_cycles", busy_cycles, NE * (WD + 1) + 1);
        check("nostall_done_count", done_count, 1);
        check("nostall_writes", writes, NE);
        check("nostall_busy_low", busy, 1'b0);
        check("nostall_sb_empty", sb.size(), 0);

        // Random in_valid gaps
        done_count = 0;
        writes     = 0;
        do_start();
        send_matrix(0, 1'b1, -1, NE, 0);
        wait_done();
        @(negedge clk);
        check("stall_done_count", done_count, 1);
        check("stall_writes", writes, NE);
        check("stall_sb_empty", sb.size(), 0);

        // start pulsed during row 5 must be ignored and must not queue a restart
        done_count = 0;
        writes     = 0;
        do_start();
        send_matrix(0, 1'b0, 5, NE, 0);
        wait_done();
        repeat (5) @(negedge clk);
        check("restart_done_count", done_count, 1);
        check("restart_writes", writes, NE);
        check("restart_no_requeue", busy, 1'b0);
        check("restart_sb_empty", sb.size(), 0);

        // Reset after 7 elements of row 3: asynchronous clear, no partial write
        writes = 0;
        do_start();
        send_matrix(0, 1'b0, -1, 3, 7);
        RESET = 1'b1;
        #1;
        check("async_rowData", bus.rowData, '0);
        check("async_rowAddr", bus.rowAddr, '0);
        check("async_busy", busy, 1'b0);
        check("async_in_ready", bus.in_ready, 1'b0);
        check("async_rowWE", bus.rowWE, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        check("midrow_writes", writes, 3);
        check("midrow_sb_empty", sb.size(), 0);

        done_count = 0;
        writes     = 0;
        do_start();
        send_matrix(32'hA0, 1'b0, -1, NE, 0);
        wait_done();

        // Back-to-back: start in the cycle after the done pulse
        @(negedge clk);
        done_count = 0;
        writes     = 0;
        do_start();
        send_matrix(32'h1000, 1'b0, -1, NE, 0);
        wait_done();
        @(negedge clk);
        check("b2b_done_count", done_count, 1);
        check("b2b_writes", writes, NE);
        check("b2b_sb_empty", sb.size(), 0);
        check("b2b_busy_low", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
